fcs_frame_ctrl: RTL
===================

# fcs_frame_ctrl

Receive-side frame controller that sits between the RMII dibit stream and the MAC consumer, alongside the FCS checker (`cksum`). It packs incoming dibits into bytes, holds each frame in an internal circular buffer, waits for the checker's verdict, and then commits the frame (minus its 4 FCS bytes) or rewinds and discards it. Committed frames are replayed as a byte stream with a valid/ready handshake and last-byte marker. Good, bad and dropped frames are counted.

## Interface

- `DEPTH`, 2048: byte buffer size; power of two, at least 64.
- `LEN_DEPTH`, 4: number of committed-frame lengths that can be queued; power of two.
- `TIMEOUT`, 16: cycles to wait in WAIT_FCS for `fcs_done` before declaring the frame bad.

- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: synchronous, active-low reset (`rst`=0 resets).
- `axiiv` in 1: dibit valid; high for the whole frame, preamble/SFD already stripped, FCS included.
- `axiid` in 2: dibit; first dibit of a byte is bits [1:0].
- `fcs_done` in 1: checker verdict ready (level; clears when the next frame starts).
- `fcs_kill` in 1: checker verdict, 1 = FCS mismatch; sampled only with `fcs_done`.
- `axiov` out 1: output byte valid.
- `axiod` out 8: output byte.
- `axiol` out 1: marks the last payload byte of a frame; qualified by `axiov`.
- `axior` in 1: consumer ready; a byte transfers on `axiov & axior`.
- `frames_ok` out 16: committed frames, saturating.
- `frames_bad` out 16: FCS fail, runt, odd dibit count or timeout; saturating.
- `frames_drop` out 16: buffer overflow or length queue full; saturating.

## Operation

- Reset values: all outputs 0, state IDLE, all pointers 0, the length queue empty, and the buffer contents treated as empty. Reset mid-frame or mid-readout discards everything.
- States: IDLE, RECV, WAIT_FCS, COMMIT, DROP.
- IDLE → RECV on `axiiv`=1.
  - If the length queue is full at entry, set the `ovf` flag. The frame is then received but not stored.
  - Clear the dibit phase (2-bit counter) and the byte count (11+ bits).
- RECV:
  - Each valid dibit shifts into a byte register.
  - On the 4th dibit, write the byte at `wr_ptr` and increment `wr_ptr` (wraps modulo DEPTH) and the byte count.
  - When the buffer is full (`wr_ptr` + 1 == `rd_ptr`, modulo DEPTH), stop writing and set `ovf`.
  - On `axiiv`=0, go to WAIT_FCS and start the timeout counter.
- WAIT_FCS:
  - `fcs_done`=1 → COMMIT if `fcs_kill`=0, `ovf`=0, the phase is 0 and the byte count ≥ 5. Otherwise → DROP.
  - Timeout counter reaches TIMEOUT → DROP, counted bad.
  - `axiiv` rises before `fcs_done` → the current frame is DROPped (bad), and the new frame's first dibit is captured as in IDLE → RECV.
- COMMIT (1 cycle):
  - Set `commit_ptr` = `wr_ptr` − 4, which excludes the FCS.
  - Push (byte count − 4) onto the length queue.
  - `frames_ok`++.
  - → IDLE.
- DROP (1 cycle):
  - Set `wr_ptr` = `commit_ptr`.
  - Increment `frames_drop` if `ovf` is set; otherwise increment `frames_bad`. Exactly one counter per frame.
  - → IDLE, or → RECV if `axiiv`=1.
- Read side: runs independently of the receive FSM.
  - While the length queue is non-empty, present bytes from `rd_ptr` up to the head length.
  - `axiol`=1 on byte number length−1 of the frame.
  - On the transfer of the last byte, pop the queue.
  - Read never passes `commit_ptr`.
- Counters saturate at 0xFFFF.

## Timing

- Byte write: the cycle after its 4th dibit is sampled.
- `fcs_done` arrives no later than TIMEOUT cycles after `axiiv` falls.
- COMMIT/DROP occupy the cycle after the verdict is sampled.
- Counter update is visible 1 cycle after COMMIT/DROP.
- `axiov` rises within 2 cycles after COMMIT when the queue was empty.
- Sustained throughput: 1 byte/cycle while `axior`=1.
- `axiod`/`axiol` hold stable while `axiov`=1 and `axior`=0.
- Simultaneous read pop and COMMIT push on the length queue are both honoured.
- A buffer-full check uses `rd_ptr` as of the current cycle; space freed by a read in the same cycle becomes usable the next cycle.

## Test plan

- Good frame: 64 bytes with valid FCS (byte i = i, bytes 60..63 = correct FCS), then `fcs_done`=1, `fcs_kill`=0 → exactly 60 bytes out with `axiod`=0..59, `axiol` only on byte 59 and `frames_ok`=1.
- Bad FCS: same frame but `fcs_kill`=1 → no `axiov`, `frames_bad`=1, `wr_ptr` restored; a following good frame reads out intact.
- Malformed: an odd dibit count (257 dibits) and a 4-byte runt, each with `fcs_kill`=0 → both dropped, `frames_bad`=2, no output.
- Overflow: DEPTH=64, `axior`=0, then send a 60-byte good frame followed by a 40-byte good frame → first frame committed, second `frames_drop`=1. Asserting `axior` yields only the first frame's 56 bytes.
- Backpressure and wrap: 10 back-to-back 100-byte good frames with `axior` toggling every cycle and DEPTH=256 → all 960 bytes in order, 10 `axiol` pulses, `frames_ok`=10.
- Timeout and reset: `fcs_done` is never asserted → DROP after 16 cycles with `frames_bad`=1. Asserting `rst`=0 mid-readout → `axiov`=0 and all counters 0 on the next cycle.

Source files
------------

// File: rtl/fcs_frame_ctrl_if.sv
// rtl/fcs_frame_ctrl_if.sv - handshake/bus bundle for the receive frame controller
//
// Purpose: groups the RMII dibit input, the FCS checker verdict, the replayed
// byte stream and the frame statistics into one interface.
// Signals:
//   axiiv/axiid          dibit valid / dibit (first dibit of a byte is [1:0])
//   fcs_done/fcs_kill    checker verdict ready / verdict is "bad FCS"
//   axiov/axiod/axiol    output byte valid / data / last payload byte
//   axior                consumer ready
//   frames_ok/bad/drop   saturating frame statistics
// Modports: master drives dibits, verdict and ready; slave is the controller.

interface fcs_frame_ctrl_if;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        fcs_done;
  logic        fcs_kill;
  logic        axiov;
  logic [7:0]  axiod;
  logic        axiol;
  logic        axior;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;
  logic [15:0] frames_drop;

  modport master (
    output axiiv, axiid, fcs_done, fcs_kill, axior,
    input  axiov, axiod, axiol, frames_ok, frames_bad, frames_drop
  );

  modport slave (
    input  axiiv, axiid, fcs_done, fcs_kill, axior,
    output axiov, axiod, axiol, frames_ok, frames_bad, frames_drop
  );
endinterface

// File: rtl/fcs_frame_ctrl.sv
// rtl/fcs_frame_ctrl.sv - receive frame buffer with FCS commit/discard and byte replay
//
// Purpose: packs RMII dibits into bytes, stores each frame in a circular byte
// buffer, waits for the FCS checker verdict, then commits the payload (frame
// minus its 4 FCS bytes) or rewinds the write pointer. Committed frames are
// replayed as a byte stream with valid/ready and a last-byte marker.
// Ports:
//   clk   sole clock, posedge
//   rst   synchronous, active-low reset
//   bus   fcs_frame_ctrl_if.slave (dibits in, verdict in, bytes out, counters out)
// Parameters:
//   DEPTH      byte buffer size (power of two, >= 64)
//   LEN_DEPTH  committed-frame length queue depth (power of two, >= 2)
//   TIMEOUT    cycles to wait for the verdict before dropping the frame

module fcs_frame_ctrl #(
  parameter int DEPTH     = 2048,
  parameter int LEN_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input logic             clk,
  input logic             rst,
  fcs_frame_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LEN_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WAIT_FCS,
    S_COMMIT,
    S_DROP
  } state_t;

  state_t          r_state;
  logic [1:0]      r_phase;
  logic [7:0]      r_shift;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic [TW-1:0]   r_timer;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_commit_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_rd_idx;
  logic [LW-1:0]   r_lq_wp;
  logic [LW-1:0]   r_lq_rp;
  logic [LW:0]     r_lq_cnt;
  logic            r_axiov;
  logic [7:0]      r_axiod;
  logic            r_axiol;
  logic [15:0]     r_ok;
  logic [15:0]     r_bad;
  logic [15:0]     r_drop;

  logic [7:0]      r_mem [DEPTH];
  logic [CW-1:0]   r_lq  [LEN_DEPTH];

  logic [7:0]      w_byte;
  logic [AW-1:0]   w_wr_next;
  logic            w_full;
  logic            w_lq_full;
  logic            w_wr_en;
  logic            w_start;
  logic            w_push;
  logic [CW-1:0]   w_head_len;
  logic            w_rd_last;
  logic            w_load;
  logic            w_pop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Dibits shift in from the top so the first dibit of a byte lands in [1:0].
  assign w_byte    = {bus.axiid, r_shift[7:2]};
  assign w_wr_next = r_wr_ptr + AW'(1);
  // One slot is kept empty so a full buffer is distinguishable from an empty one.
  assign w_full    = (w_wr_next == r_rd_ptr);
  assign w_lq_full = (r_lq_cnt == (LW+1)'(LEN_DEPTH));
  assign w_wr_en   = (r_state == S_RECV) && bus.axiiv && (r_phase == 2'd3) &&
                     !r_ovf && !w_full;
  // A new frame may begin in IDLE, during a DROP, or while still waiting for a
  // verdict that never came (the old frame is abandoned as bad).
  assign w_start   = bus.axiiv && ((r_state == S_IDLE) || (r_state == S_DROP) ||
                     ((r_state == S_WAIT_FCS) && !bus.fcs_done));
  assign w_push    = (r_state == S_COMMIT);

  assign w_head_len = r_lq[r_lq_rp];
  assign w_rd_last  = (r_rd_idx == w_head_len - CW'(1));
  // The output register refills whenever it is empty or being consumed.
  assign w_load     = (r_lq_cnt != '0) && (!r_axiov || bus.axior);
  assign w_pop      = w_load && w_rd_last;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lq[r_lq_wp] <= r_cnt - CW'(4);
    end
  end

  // Receive FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_timer      <= '0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_ok         <= '0;
      r_bad        <= '0;
      r_drop       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
        end
        S_RECV: begin
          if (bus.axiiv) begin
            r_shift <= w_byte;
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd3) begin
              r_cnt <= r_cnt + CW'(1);
              if (w_wr_en) begin
                r_wr_ptr <= w_wr_next;
              end else begin
                r_ovf <= 1'b1;
              end
            end
          end else begin
            r_state <= S_WAIT_FCS;
            r_timer <= '0;
          end
        end
        S_WAIT_FCS: begin
          if (bus.fcs_done) begin
            if (!bus.fcs_kill && !r_ovf && (r_phase == 2'd0) && (r_cnt >= CW'(5))) begin
              r_state <= S_COMMIT;
            end else begin
              r_state <= S_DROP;
            end
          end else if (bus.axiiv) begin
            // Abandon the unverified frame; w_start below opens the new one.
            r_bad    <= sat_inc(r_bad);
            r_wr_ptr <= r_commit_ptr;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_state <= S_DROP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_COMMIT: begin
          // The FCS bytes are reclaimed so the next frame follows the payload.
          r_commit_ptr <= r_wr_ptr - AW'(4);
          r_wr_ptr     <= r_wr_ptr - AW'(4);
          r_ok         <= sat_inc(r_ok);
          r_state      <= S_IDLE;
        end
        S_DROP: begin
          r_wr_ptr <= r_commit_ptr;
          if (r_ovf) begin
            r_drop <= sat_inc(r_drop);
          end else begin
            r_bad <= sat_inc(r_bad);
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_start) begin
        r_state <= S_RECV;
        r_ovf   <= w_lq_full;
        r_phase <= 2'd1;
        r_cnt   <= '0;
        r_shift <= w_byte;
      end
    end
  end

  // Read side: length queue bookkeeping and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lq_wp  <= '0;
      r_lq_rp  <= '0;
      r_lq_cnt <= '0;
      r_rd_ptr <= '0;
      r_rd_idx <= '0;
      r_axiov  <= 1'b0;
      r_axiod  <= '0;
      r_axiol  <= 1'b0;
    end else begin
      if (w_push) begin
        r_lq_wp <= r_lq_wp + LW'(1);
      end
      if (w_pop) begin
        r_lq_rp <= r_lq_rp + LW'(1);
      end
      r_lq_cnt <= r_lq_cnt + (LW+1)'(w_push) - (LW+1)'(w_pop);

      if (w_load) begin
        r_axiov  <= 1'b1;
        r_axiod  <= r_mem[r_rd_ptr];
        r_axiol  <= w_rd_last;
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rd_idx <= w_rd_last ? '0 : r_rd_idx + CW'(1);
      end else if (bus.axior) begin
        r_axiov <= 1'b0;
      end
    end
  end

  assign bus.axiov       = r_axiov;
  assign bus.axiod       = r_axiod;
  assign bus.axiol       = r_axiol;
  assign bus.frames_ok   = r_ok;
  assign bus.frames_bad  = r_bad;
  assign bus.frames_drop = r_drop;

endmodule
